i2c_reg_target: RTL and testbench

- Register-mapped I2C target (responder) that answers i2c_master transactions: write pointer, burst write, burst read with auto-increment.
- Fully synchronous to the system clk: SCL/SDA are synchronised and oversampled, and no logic is clocked by SCL.
- Bridges the bus to a flat register space through a one-cycle write strobe and a combinational read port.
- clk must be at least 16x the SCL frequency.

---
 rtl/i2c_reg_target.sv | 159 +++++++++++++++
 tb/tb_i2c_reg_target.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C register-mapped target with pointer write, burst write and auto-increment burst read
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA (+2 clk per edge).
// Ports:
//   clk       system clock, must be at least 16x SCL
//   rst       asynchronous active-low reset
//   addr      own 7-bit address
//   SCL, SDA  I2C bus; SDA is open-drain (driven 0 or released)
//   busy      high while a transaction is in progress (state != IDLE)
//   wr_en     one-cycle write strobe with wr_ptr/wr_data
//   rd_ptr    current register index; rd_data returns its contents combinationally
//   rd_strobe one-cycle pulse when rd_data is captured for transmission
module i2c_reg_target #(
    parameter int PTR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       addr,
    input  logic             SCL,
    inout  wire              SDA,
    output logic             busy,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_ptr,
    input  logic [7:0]       rd_data,
    output logic             rd_strobe
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_q, sda_q;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
    logic [7:0]             sh, nb;
    logic [3:0]             cnt;
    logic [PTR_W-1:0]       ptr;
    logic                   sda_oe;

    // Lines reset to the idle-high bus level so leaving reset creates no false edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [2:0] scl_h, sda_h;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_h <= '1;
            sda_h <= '1;
        end else begin
            scl_h <= {scl_h[1:0], scl_sync[SYNC_STAGES-1]};
            sda_h <= {sda_h[1:0], sda_sync[SYNC_STAGES-1]};
        end
    end
    assign scl_s = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
    assign sda_s = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign sda_rise  = sda_s & ~sda_q;
    assign sda_fall  = ~sda_s & sda_q;
    assign start     = scl_s & sda_fall;
    assign stop      = scl_s & sda_rise;
    assign nb        = {sh[6:0], sda_s};
    assign busy      = (state != IDLE);
    assign rd_ptr    = ptr;
    assign SDA       = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        state_nx = state;
        if (start)
            state_nx = ADDR;
        else if (stop)
            state_nx = IDLE;
        else case (state)
            ADDR:               if (cnt == 4'd8) state_nx = (sh[7:1] != addr) ? WAIT_STOP : scl_fall ? ADDR_ACK : ADDR;
            PTR:                if (cnt == 4'd8 && scl_fall) state_nx = PTR_ACK;
            WDATA:              if (cnt == 4'd8 && scl_fall) state_nx = WDATA_ACK;
            ADDR_ACK:           if (scl_fall) state_nx = sh[0] ? RDATA : PTR;
            PTR_ACK, WDATA_ACK: if (scl_fall) state_nx = WDATA;
            RDATA:              if (scl_fall && cnt == 4'd7) state_nx = RDATA_ACK;
            // NACK leaves at the sampling edge; reaching the falling edge here means the master ACKed
            RDATA_ACK:          state_nx = (scl_rise && sda_s) ? WAIT_STOP : scl_fall ? RDATA : RDATA_ACK;
            default:            ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            wr_en     <= 1'b0;
            wr_ptr    <= '0;
            wr_data   <= '0;
            rd_strobe <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_en     <= 1'b0;
            rd_strobe <= 1'b0;
            if (wr_en)
                ptr <= ptr + PTR_W'(1);
            // Entry actions: every state change restarts the bit count and sets the SDA drive for the new state.
            if (state_nx != state || start) begin
                cnt    <= '0;
                sda_oe <= (state_nx inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) || (state_nx == RDATA && !rd_data[7]);
                if (state_nx == RDATA) begin
                    sh        <= rd_data;
                    rd_strobe <= 1'b1;
                end
            end else case (state)
                ADDR, PTR, WDATA: if (scl_rise && cnt != 4'd8) begin
                    sh  <= nb;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7 && state == PTR)
                        ptr <= nb[PTR_W-1:0];
                    if (cnt == 4'd7 && state == WDATA) begin
                        wr_en   <= 1'b1;
                        wr_ptr  <= ptr;
                        wr_data <= nb;
                    end
                end
                RDATA: if (scl_fall) begin
                    cnt    <= cnt + 4'd1;
                    sh     <= {sh[6:0], 1'b0};
                    sda_oe <= ~sh[6];
                end
                RDATA_ACK: if (scl_rise && !sda_s)
                    ptr <= ptr + PTR_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: directed I2C master stimulus with a scoreboard on wr_en/rd_strobe
module tb_i2c_reg_target;
    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [6:0] addr = 7'h42;
    wire        sda;
    logic       busy, wr_en, rd_strobe;
    logic [3:0] wr_ptr, rd_ptr;
    logic [7:0] wr_data, rd_data;
    logic [7:0] regs [16];
    int         total = 0;
    int         bad = 0;
    logic [11:0] wr_q[$];
    logic [3:0]  rd_q[$];

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);
    assign rd_data = regs[rd_ptr];

    always #5 clk = ~clk;

    i2c_reg_target #(.PTR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .SCL(scl), .SDA(sda), .busy(busy),
        .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_data(wr_data),
        .rd_ptr(rd_ptr), .rd_data(rd_data), .rd_strobe(rd_strobe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] ew;
        logic [3:0]  er;
        if (wr_en) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got ptr=%0d data=%h want no write", wr_ptr, wr_data);
            end else begin
                ew = wr_q.pop_front();
                if ({wr_ptr, wr_data} !== ew) begin
                    bad++;
                    $display("FAIL wr_strobe: got ptr=%0d data=%h want ptr=%0d data=%h", wr_ptr, wr_data, ew[11:8], ew[7:0]);
                end
            end
        end
        if (rd_strobe) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: got rd_ptr=%0d want no read", rd_ptr);
            end else begin
                er = rd_q.pop_front();
                if (rd_ptr !== er) begin
                    bad++;
                    $display("FAIL rd_strobe: got rd_ptr=%0d want %0d", rd_ptr, er);
                end
            end
        end
    end

    task automatic bit_io(input logic v, output logic s);
        m_low = ~v;
        #Q scl = 1'b1;
        #Q s = sda;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic start_c;
        m_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic stop_c;
        m_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_low = 1'b0;
        #(4*Q);
    endtask

    task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        chk(name, 32'(s), 32'(exp_ack));
    endtask

    task automatic rbyte(input logic ack, input logic [7:0] exp, input string name);
        logic       s;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(ack, s);
        chk(name, 32'(d), 32'(exp));
    endtask

    initial begin
        logic s;
        for (int i = 0; i < 16; i++) regs[i] = {4'(i), ~4'(i)};
        regs[5] = 8'h11;
        regs[6] = 8'h22;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({wr_en, rd_strobe}), 0);
        chk("rst_ptrs", 32'({rd_ptr, wr_ptr, wr_data}), 0);
        chk("rst_sda", 32'(sda), 1);
        rst = 1'b1;
        #(4*Q);

        // write burst: pointer 3, data A5 -> reg 3, 5A -> reg 4
        start_c;
        wbyte(8'h84, 1'b0, "wb_addr_ack");
        wbyte(8'h03, 1'b0, "wb_ptr_ack");
        wr_q.push_back({4'd3, 8'hA5});
        wbyte(8'hA5, 1'b0, "wb_d0_ack");
        wr_q.push_back({4'd4, 8'h5A});
        wbyte(8'h5A, 1'b0, "wb_d1_ack");
        chk("wb_busy_mid", 32'(busy), 1);
        stop_c;
        chk("wb_busy_end", 32'(busy), 0);
        chk("wb_ptr_end", 32'(rd_ptr), 5);

        // pointer set then repeated-START read of two bytes
        start_c;
        wbyte(8'h84, 1'b0, "rd_waddr_ack");
        wbyte(8'h05, 1'b0, "rd_ptr_ack");
        start_c;
        rd_q.push_back(4'd5);
        rd_q.push_back(4'd6);
        wbyte(8'h85, 1'b0, "rd_raddr_ack");
        rbyte(1'b0, 8'h11, "rd_byte0");
        rbyte(1'b1, 8'h22, "rd_byte1");
        chk("rd_wait_stop_busy", 32'(busy), 1);
        chk("rd_ptr_after_nack", 32'(rd_ptr), 6);
        chk("rd_sda_released", 32'(sda), 1);
        stop_c;
        chk("rd_busy_end", 32'(busy), 0);

        // address mismatch: no ACK anywhere, busy until STOP
        start_c;
        wbyte(8'h90, 1'b1, "mm_addr_nack");
        wbyte(8'h12, 1'b1, "mm_data_nack");
        chk("mm_busy", 32'(busy), 1);
        stop_c;
        chk("mm_busy_end", 32'(busy), 0);

        // pointer wrap 15 -> 0
        start_c;
        wbyte(8'h84, 1'b0, "wr_addr_ack");
        wbyte(8'h0F, 1'b0, "wr_ptr_ack");
        wr_q.push_back({4'd15, 8'hC3});
        wbyte(8'hC3, 1'b0, "wr_d0_ack");
        wr_q.push_back({4'd0, 8'h3C});
        wbyte(8'h3C, 1'b0, "wr_d1_ack");
        stop_c;
        chk("wrap_ptr_end", 32'(rd_ptr), 1);

        // START mid-WDATA byte: partial byte dropped, new read address decoded, pointer kept
        start_c;
        wbyte(8'h84, 1'b0, "ab_waddr_ack");
        wbyte(8'h02, 1'b0, "ab_ptr_ack");
        bit_io(1'b1, s);
        bit_io(1'b0, s);
        bit_io(1'b1, s);
        start_c;
        rd_q.push_back(4'd2);
        wbyte(8'h85, 1'b0, "ab_raddr_ack");
        rbyte(1'b1, 8'h2D, "ab_byte");
        stop_c;
        chk("ab_busy_end", 32'(busy), 0);

        // reset while driving a read bit low
        start_c;
        wbyte(8'h84, 1'b0, "rs_waddr_ack");
        wbyte(8'h07, 1'b0, "rs_ptr_ack");
        start_c;
        rd_q.push_back(4'd7);
        wbyte(8'h85, 1'b0, "rs_raddr_ack");
        chk("rs_driving_low", 32'(sda), 0);
        rst = 1'b0;
        #1;
        chk("rs_sda_released", 32'(sda), 1);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_outputs", 32'({wr_en, rd_strobe, rd_ptr, wr_ptr, wr_data}), 0);
        #(2*Q) rst = 1'b1;
        stop_c;
        chk("rs_idle_after", 32'(busy), 0);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // a single-clock SDA dip while SCL is high must not look like START
        @(posedge clk);
        #1 m_low = 1'b1;
        @(posedge clk);
        #1 m_low = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("gf_no_start", 32'(busy), 0);
`endif

        repeat (20) @(posedge clk);
        chk("sb_wr_drained", 32'(wr_q.size()), 0);
        chk("sb_rd_drained", 32'(rd_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
